// File: rtl/add_sub_pkg.sv
// Shared widths, constants and the stage-1 payload for the add/sub post-normalizer.
package add_sub_pkg;

  localparam int unsigned SIZE_EXP = 8;
  localparam int unsigned SIZE_SUM = 33;
  localparam int unsigned SIZE_MAN = SIZE_SUM - 1;
  localparam int unsigned SIZE_LZC = 6;
  localparam int unsigned SIZE_EXW = SIZE_EXP + 1;

  localparam logic [SIZE_EXP-1:0] EXP_MAX = 8'd255;

  typedef struct packed {
    logic                sign;
    logic [SIZE_EXP-1:0] exp;
    logic [SIZE_SUM-1:0] sum;
    logic                carry;
    logic [SIZE_LZC-1:0] lz;
    logic                allz;
  } s1_t;

endpackage

// File: rtl/add_sub_lzc.sv
// Combinational leading-zero counter; count equals the width when no bit is set.
module add_sub_lzc
  import add_sub_pkg::*;
(
  input  logic [SIZE_MAN-1:0] data,
  output logic [SIZE_LZC-1:0] count,
  output logic                all_zero
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    count = SIZE_LZC'(SIZE_MAN);
    for (int i = 0; i < int'(SIZE_MAN); i++) begin
      if (data[i]) count = SIZE_LZC'(int'(SIZE_MAN) - 1 - i);
    end
  end

  assign all_zero = ~|data;

endmodule

// File: rtl/add_sub_normalize.sv
// Two-stage elastic normalizer: stage 1 finds the leading one, stage 2 shifts
// it out and adjusts the exponent, flagging zero, underflow and overflow.
module add_sub_normalize
  import add_sub_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign,
  input  logic [SIZE_EXP-1:0] i_exp,
  input  logic [SIZE_SUM-1:0] i_sum,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sign,
  output logic [SIZE_EXP-1:0] o_exp,
  output logic [SIZE_MAN-1:0] o_man,
  output logic                o_zero,
  output logic                o_underflow,
  output logic                o_exp_ov
);

  logic                s1_valid;
  s1_t                 s1_q;
  logic                s1_en;
  logic                s2_en;
  logic [SIZE_LZC-1:0] lz_cnt;
  logic                lz_allz;

  assign s2_en   = ~o_valid | i_ready;
  assign s1_en   = ~s1_valid | s2_en;
  assign o_ready = s1_en;

  add_sub_lzc u_lzc (
    .data     (i_sum[SIZE_MAN-1:0]),
    .count    (lz_cnt),
    .all_zero (lz_allz)
  );

  // Stage 1: capture operand and leading-zero information.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_q.sign  <= i_sign;
        s1_q.exp   <= i_exp;
        s1_q.sum   <= i_sum;
        s1_q.carry <= i_sum[SIZE_SUM-1];
        s1_q.lz    <= lz_cnt;
        s1_q.allz  <= lz_allz & ~i_sum[SIZE_SUM-1];
      end
    end
  end

  logic                n_sign;
  logic [SIZE_EXP-1:0] n_exp;
  logic [SIZE_MAN-1:0] n_man;
  logic                n_zero;
  logic                n_uf;
  logic                n_ov;
  logic [SIZE_EXW-1:0] exp_w;
  logic [SIZE_EXW-1:0] exp_inc;
  logic [SIZE_EXW-1:0] lz_w;
  logic [SIZE_EXW-1:0] exp_sub;
  logic [SIZE_LZC-1:0] shamt;

  // Stage 2 next values; exponent math is one bit wider so nothing wraps.
  always_comb begin
    exp_w   = SIZE_EXW'(s1_q.exp);
    exp_inc = exp_w + SIZE_EXW'(1);
    lz_w    = SIZE_EXW'(s1_q.lz);
    exp_sub = exp_w - lz_w;
    shamt   = s1_q.lz + SIZE_LZC'(1);

    n_sign = s1_q.sign;
    n_exp  = '0;
    n_man  = '0;
    n_zero = 1'b0;
    n_uf   = 1'b0;
    n_ov   = 1'b0;

    if (s1_q.allz) begin
      n_zero = 1'b1;
      n_sign = 1'b0;
    end else if (s1_q.carry) begin
      if (exp_inc >= SIZE_EXW'(EXP_MAX)) begin
        n_exp = EXP_MAX;
        n_ov  = 1'b1;
      end else begin
        n_exp = SIZE_EXP'(exp_inc);
        n_man = s1_q.sum[SIZE_MAN-1:0];
      end
    end else if (exp_w <= lz_w) begin
      n_uf = 1'b1;
    end else begin
      n_exp = SIZE_EXP'(exp_sub);
      n_man = s1_q.sum[SIZE_MAN-1:0] << shamt;
    end
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_sign      <= 1'b0;
      o_exp       <= '0;
      o_man       <= '0;
      o_zero      <= 1'b0;
      o_underflow <= 1'b0;
      o_exp_ov    <= 1'b0;
    end else if (s2_en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_sign      <= n_sign;
        o_exp       <= n_exp;
        o_man       <= n_man;
        o_zero      <= n_zero;
        o_underflow <= n_uf;
        o_exp_ov    <= n_ov;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_normalize.sv
// Self-checking bench for add_sub_normalize: directed cases, backpressure,
// async reset and randomized traffic against an arithmetic reference model.
module tb_add_sub_normalize;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [31:0] man;
    logic        zero;
    logic        uf;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sign = 1'b0;
  logic [7:0]  i_exp = '0;
  logic [32:0] i_sum = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_sign;
  logic [7:0]  o_exp;
  logic [31:0] o_man;
  logic        o_zero;
  logic        o_underflow;
  logic        o_exp_ov;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  res_t held;
  bit   prev_stall = 0;
  bit   last_acc = 0;
  bit   last_ready = 0;

  always #5 clk = ~clk;

  add_sub_normalize dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_sum       (i_sum),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sign      (o_sign),
    .o_exp       (o_exp),
    .o_man       (o_man),
    .o_zero      (o_zero),
    .o_underflow (o_underflow),
    .o_exp_ov    (o_exp_ov)
  );

  // Reference: locate the leading one arithmetically, strip it, left-align the rest.
  function automatic res_t model(logic s, logic [7:0] e, logic [32:0] sum);
    res_t   r;
    int     p;
    int     lz;
    longint ue;
    longint v;
    r  = '0;
    ue = longint'(e);
    v  = longint'(sum);
    if (v == 0) begin
      r.zero = 1'b1;
    end else if (v >= 64'sd4294967296) begin
      r.sign = s;
      if (ue + 1 >= 255) begin
        r.exp = 8'd255;
        r.ov  = 1'b1;
      end else begin
        r.exp = 8'(ue + 1);
        r.man = 32'(v - 64'sd4294967296);
      end
    end else begin
      r.sign = s;
      p = 31;
      while ((v >> p) == 0) p--;
      lz = 31 - p;
      if (ue <= longint'(lz)) begin
        r.uf = 1'b1;
      end else begin
        r.exp = 8'(ue - longint'(lz));
        r.man = 32'((v - (64'sd1 << p)) << (32 - p));
      end
    end
    return r;
  endfunction

  function automatic res_t actual();
    return {o_sign, o_exp, o_man, o_zero, o_underflow, o_exp_ov};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: settle, score any output transfer, record any input transfer.
  task automatic cycle();
    res_t cur;
    #1;
    cur = actual();
    last_ready = o_ready;
    if (prev_stall) check("stall_hold", 64'(cur), 64'(held));
    if (o_valid && i_ready) begin
      if (q.size() == 0) check("unexpected_out", 64'(1), 64'(0));
      else check("result", 64'(cur), 64'(q.pop_front()));
    end
    last_acc = i_valid && o_ready && !rst;
    if (last_acc) q.push_back(model(i_sign, i_exp, i_sum));
    prev_stall = o_valid && !i_ready;
    held = cur;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [32:0] sum);
    i_valid = v;
    i_sign  = s;
    i_exp   = e;
    i_sum   = sum;
  endtask

  task automatic drain();
    int budget;
    budget = 50;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic rand_operand();
    logic [7:0]  e;
    logic [32:0] sum;
    int          kind;
    kind = int'($urandom_range(0, 5));
    case ($urandom_range(0, 7))
      0: e = 8'd0;
      1: e = 8'd1;
      2: e = 8'd254;
      3: e = 8'd255;
      default: e = 8'($urandom);
    endcase
    case (kind)
      0: sum = '0;
      1: sum = {1'b1, 32'($urandom)};
      2: sum = {1'b0, 32'($urandom) >> $urandom_range(0, 31)};
      default: sum = {1'b0, 32'($urandom)};
    endcase
    drive(1'b1, 1'($urandom), e, sum);
  endtask

  initial begin
    int    acc_cnt;
    int    budget;
    res_t  exp_r;

    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("reset_valid", 64'(o_valid), 64'(0));
    check("reset_outputs", 64'(actual()), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Carry normalization and two-cycle latency.
    i_ready = 1'b1;
    drive(1'b1, 1'b0, 8'd127, 33'h1_0000_0000);
    exp_r = '{sign: 1'b0, exp: 8'd128, man: 32'h0, zero: 1'b0, uf: 1'b0, ov: 1'b0};
    cycle();
    check("accept_first", 64'(last_acc), 64'(1));
    void'(q.pop_back());
    q.push_back(exp_r);
    i_valid = 1'b0;
    check("lat_cycle1", 64'(o_valid), 64'(0));
    cycle();
    check("lat_cycle2", 64'(o_valid), 64'(1));
    drain();

    // Directed table, back-to-back, expectations written out by hand.
    drive(1'b1, 1'b0, 8'd127, 33'h0_8000_0001); cycle(); void'(q.pop_back());
    q.push_back('{1'b0, 8'd127, 32'h0000_0002, 1'b0, 1'b0, 1'b0});
    drive(1'b1, 1'b1, 8'd100, 33'h0_0000_0180); cycle(); void'(q.pop_back());
    q.push_back('{1'b1, 8'd77, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
    drive(1'b1, 1'b0, 8'd5, 33'h0_0001_0000); cycle(); void'(q.pop_back());
    q.push_back('{1'b0, 8'd0, 32'h0, 1'b0, 1'b1, 1'b0});
    drive(1'b1, 1'b0, 8'd254, 33'h1_0000_0000); cycle(); void'(q.pop_back());
    q.push_back('{1'b0, 8'd255, 32'h0, 1'b0, 1'b0, 1'b1});
    drive(1'b1, 1'b1, 8'd77, 33'h0); cycle(); void'(q.pop_back());
    q.push_back('{1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 1'b0});
    drive(1'b1, 1'b1, 8'd0, 33'h0_0000_0001); cycle(); void'(q.pop_back());
    q.push_back('{1'b1, 8'd0, 32'h0, 1'b0, 1'b1, 1'b0});
    drain();

    // Backpressure: four operands, downstream stalled for three cycles.
    acc_cnt = 0;
    for (int cyc = 0; cyc < 20 && acc_cnt < 4; cyc++) begin
      i_ready = (cyc >= 3);
      drive(1'b1, 1'b0, 8'(120 + acc_cnt), {1'b0, 32'h0001_0000 << acc_cnt});
      cycle();
      if (last_acc) acc_cnt++;
      if (cyc == 2) begin
        check("bp_accepts", 64'(acc_cnt), 64'(2));
        check("bp_ready_low", 64'(last_ready), 64'(0));
      end
    end
    check("bp_all_accepted", 64'(acc_cnt), 64'(4));
    drain();

    // Randomized traffic with random valid and ready.
    for (int n = 0; n < 400; n++) begin
      i_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) rand_operand();
      else i_valid = 1'b0;
      cycle();
    end
    drain();

    // Asynchronous reset with both stages occupied.
    i_ready = 1'b0;
    drive(1'b1, 1'b0, 8'd130, 33'h0_4000_0000); cycle();
    drive(1'b1, 1'b1, 8'd131, 33'h1_2345_6789); cycle();
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(o_valid), 64'(0));
    check("async_rst_outputs", 64'(actual()), 64'(0));
    q.delete();
    prev_stall = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    i_ready = 1'b1;
    drive(1'b1, 1'b0, 8'd10, 33'h0_0000_0003); cycle();
    i_valid = 1'b0;
    check("post_rst_c1", 64'(o_valid), 64'(0));
    cycle();
    check("post_rst_c2", 64'(o_valid), 64'(1));
    drain();

    // Nothing may appear after everything has drained.
    budget = 3;
    while (budget > 0) begin
      cycle();
      budget--;
    end
    check("idle_valid", 64'(o_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
